// File: rtl/mux_scan_nway.sv
// N-way registered word selector with manual select, round-robin auto-scan
// and sample-and-hold freeze. All outputs are registered; no input-to-output paths.
module mux_scan_nway #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      chan_change,
  output logic                      sel_err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CHAN_MAX = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_SCAN,
    ST_HOLD
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_cur;
  logic [SEL_W-1:0]    chan_reg, chan_next;
  logic [WIDTH-1:0]    data_reg, data_next, word_sel;
  logic                chg_reg;
  logic                err_reg, err_next;
  logic                sel_ok;
  logic [WIDTH-1:0]    words [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_words
      assign words[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Only reachable false when CHANNELS is not a power of two.
  assign sel_ok = (int'(sel) < CHANNELS);

  always_comb begin
    state_next = hold ? ST_HOLD : (mode ? ST_SCAN : ST_MANUAL);
    // A scan entered straight from manual always starts a fresh dwell.
    cnt_cur    = (state_reg == ST_MANUAL) ? '0 : cnt_reg;
    cnt_next   = cnt_reg;
    chan_next  = chan_reg;
    err_next   = 1'b0;

    case (state_next)
      ST_HOLD: begin
        cnt_next  = cnt_reg;
        chan_next = chan_reg;
      end
      ST_SCAN: begin
        if (cnt_cur == CNT_MAX) begin
          cnt_next  = '0;
          chan_next = (chan_reg == CHAN_MAX) ? '0 : chan_reg + 1'b1;
        end else begin
          cnt_next = cnt_cur + 1'b1;
        end
      end
      default: begin
        cnt_next = '0;
        if (sel_ok) begin
          chan_next = sel;
        end else begin
          err_next = 1'b1;
        end
      end
    endcase

    word_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (chan_next == SEL_W'(k)) begin
        word_sel = words[k];
      end
    end

    if (state_next == ST_HOLD) begin
      data_next = data_reg;
    end else if (state_next == ST_MANUAL && !sel_ok) begin
      data_next = '0;
    end else begin
      data_next = word_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_MANUAL;
      cnt_reg   <= '0;
      chan_reg  <= '0;
      data_reg  <= '0;
      chg_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      chan_reg  <= chan_next;
      data_reg  <= data_next;
      chg_reg   <= (chan_next != chan_reg);
      err_reg   <= err_next;
    end
  end

  assign data_out    = data_reg;
  assign chan_out    = chan_reg;
  assign chan_change = chg_reg;
  assign sel_err     = err_reg;

endmodule

// File: tb/tb_mux_scan_nway.sv
// Bench for mux_scan_nway: two instances (4 channels/dwell 3, 3 channels/dwell 2)
// checked every cycle against a tick-count model, plus directed literal checks.
module tb_mux_scan_nway;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        mode;
  logic [1:0]  sel;
  logic        hold;

  logic [3:0]  dout   [2];
  logic [1:0]  chan   [2];
  logic        chg    [2];
  logic        err    [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mux_scan_nway #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .mode(mode), .sel(sel),
    .hold(hold), .data_out(dout[0]), .chan_out(chan[0]),
    .chan_change(chg[0]), .sel_err(err[0])
  );

  mux_scan_nway #(.WIDTH(4), .CHANNELS(3), .DWELL(2)) dut3 (
    .clock(clock), .reset(reset), .data_in(data_in[11:0]), .mode(mode), .sel(sel),
    .hold(hold), .data_out(dout[1]), .chan_out(chan[1]),
    .chan_change(chg[1]), .sel_err(err[1])
  );

  // Model: in scan the channel is base + (elapsed dwell ticks / DWELL), modulo CHANNELS.
  int chs [2] = '{4, 3};
  int dws [2] = '{3, 2};
  int m_chan [2], m_data [2], m_chg [2], m_err [2], m_ticks [2], m_base [2];
  bit m_valid = 0;

  function automatic int word_of(logic [15:0] d, int k);
    return int'((d >> (k * 4)) & 16'h000F);
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      int nc;
      if (reset) begin
        m_chan[i] = 0; m_data[i] = 0; m_chg[i] = 0; m_err[i] = 0;
        m_ticks[i] = 0; m_base[i] = 0;
      end else if (hold) begin
        m_chg[i] = 0; m_err[i] = 0;
      end else if (mode) begin
        m_ticks[i] = m_ticks[i] + 1;
        nc = (m_base[i] + m_ticks[i] / dws[i]) % chs[i];
        m_chg[i]  = (nc != m_chan[i]) ? 1 : 0;
        m_chan[i] = nc;
        m_data[i] = word_of(data_in, nc);
        m_err[i]  = 0;
      end else begin
        if (int'(sel) < chs[i]) begin
          nc = int'(sel);
          m_data[i] = word_of(data_in, nc);
          m_err[i]  = 0;
        end else begin
          nc = m_chan[i];
          m_data[i] = 0;
          m_err[i]  = 1;
        end
        m_chg[i]   = (nc != m_chan[i]) ? 1 : 0;
        m_chan[i]  = nc;
        m_ticks[i] = 0;
        m_base[i]  = nc;
      end
    end
    if (reset) m_valid = 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model data_out[%0d]", i), int'(dout[i]), m_data[i]);
        chk($sformatf("model chan_out[%0d]", i), int'(chan[i]), m_chan[i]);
        chk($sformatf("model chan_change[%0d]", i), int'(chg[i]), m_chg[i]);
        chk($sformatf("model sel_err[%0d]", i), int'(err[i]), m_err[i]);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    reset = 1; mode = 0; hold = 0; sel = 0; data_in = 16'h0000;
    step(2);
    chk("reset data_out", int'(dout[0]), 0);
    chk("reset chan_out", int'(chan[0]), 0);
    chk("reset chan_change", int'(chg[0]), 0);
    chk("reset sel_err", int'(err[0]), 0);

    // Manual select of channel 2
    reset = 0; data_in = 16'hDCBA; sel = 2;
    step();
    chk("t1 data_out", int'(dout[0]), 12);
    chk("t1 chan_out", int'(chan[0]), 2);
    chk("t1 chan_change pulse", int'(chg[0]), 1);
    step();
    chk("t1 chan_change steady", int'(chg[0]), 0);

    // Scan, DWELL=3, from channel 0
    sel = 0; step();
    mode = 1;
    step(2);
    chk("t2 dwell chan", int'(chan[0]), 0);
    step();
    chk("t2 first advance chan", int'(chan[0]), 1);
    chk("t2 first advance data", int'(dout[0]), 11);
    step(9);
    chk("t2 wrap chan", int'(chan[0]), 0);
    chk("t2 wrap data", int'(dout[0]), 10);
    chk("t2 wrap pulse", int'(chg[0]), 1);

    // Hold one cycle into a dwell
    step();
    hold = 1; data_in = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3 hold chan", int'(chan[0]), 0);
      chk("t3 hold data", int'(dout[0]), 10);
    end
    hold = 0;
    step();
    chk("t3 release chan", int'(chan[0]), 0);
    step();
    chk("t3 advance chan", int'(chan[0]), 1);
    chk("t3 advance data", int'(dout[0]), 2);

    // Scan -> manual with sel=3 while on channel 1
    data_in = 16'hDCBA; mode = 0; sel = 3;
    step();
    chk("t6 chan", int'(chan[0]), 3);
    chk("t6 data", int'(dout[0]), 13);
    chk("t6 pulse", int'(chg[0]), 1);
    chk("t4 3ch sel_err", int'(err[1]), 1);
    chk("t4 3ch data zero", int'(dout[1]), 0);
    sel = 1;
    step();
    chk("t4 3ch sel_err clear", int'(err[1]), 0);
    chk("t4 3ch data word1", int'(dout[1]), 11);

    // Reset mid-dwell, then a fresh full dwell from channel 0
    mode = 1;
    step(4);
    reset = 1;
    step();
    chk("t5 reset chan", int'(chan[0]), 0);
    chk("t5 reset data", int'(dout[0]), 0);
    reset = 0;
    step(2);
    chk("t5 full dwell chan", int'(chan[0]), 0);
    step();
    chk("t5 advance chan", int'(chan[0]), 1);

    // Randomized phase
    for (int k = 0; k < 4000; k++) begin
      data_in = 16'($urandom);
      sel     = 2'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 11) == 0) hold = ~hold;
      reset   = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0; hold = 0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_nway.md
Name: mux_scan_nway

Overview:
- Parametrised successor to the team's single-bit 2:1 mux: selects one of CHANNELS words of WIDTH bits onto a registered output.
- Adds two sequential modes. In manual mode, the host selects the channel. In auto-scan mode, the block round-robins through the channels, dwelling DWELL cycles on each.
- A hold input freezes the output as a sample-and-hold.
- Sits between the switch/sensor inputs and the LEDR/HEX display path on the board top level.

Parameters:
- WIDTH, 4, bits per channel word (>=1)
- CHANNELS, 4, number of input channels (>=2)
- DWELL, 8, cycles spent on each channel in auto-scan mode (>=1)
- SEL_W (localparam), $clog2(CHANNELS), width of the channel index

Ports:
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- data_in  in  CHANNELS*WIDTH  packed channel words; channel k occupies bits [k*WIDTH +: WIDTH]
- mode  in  1  0 = manual, 1 = auto-scan
- sel  in  SEL_W  manual channel select
- hold  in  1  freeze channel, dwell counter and data_out
- data_out  out  WIDTH  registered selected word
- chan_out  out  SEL_W  currently selected channel (registered)
- chan_change  out  1  one-cycle pulse when chan_out changes value
- sel_err  out  1  registered flag: manual sel out of range this cycle

Behaviour:

Reset (reset=1 at a rising edge):
- data_out=0, chan_out=0, chan_change=0, sel_err=0.
- Internal dwell counter = 0; state = MANUAL.
- Reset overrides all other inputs, including mid-dwell and mid-hold.

States:
- MANUAL, SCAN, HOLD.
- Each cycle, the next state is HOLD if hold=1, else SCAN if mode=1, else MANUAL. Hold has priority over mode.

Data path:
- data_out <= word of chan_next each cycle, where chan_next is the chan_out value being loaded that edge.
- Latency from data_in or sel to data_out is 1 cycle.
- There is no combinational path from inputs to outputs.

MANUAL:
- If sel < CHANNELS: chan_out <= sel, sel_err <= 0.
- If sel >= CHANNELS (non-power-of-2 CHANNELS only): chan_out is unchanged, data_out <= 0, sel_err <= 1.
- Dwell counter is held at 0.

SCAN:
- Dwell counter increments each cycle.
- When counter == DWELL-1: counter <= 0, and chan_out <= (chan_out == CHANNELS-1) ? 0 : chan_out+1.
- Wrap-around from the last channel to 0 is exact.
- sel is ignored; sel_err <= 0.
- With DWELL=1, the channel advances every cycle.

HOLD:
- chan_out, dwell counter and data_out keep their values; data_in changes are ignored.
- sel_err <= 0.
- On release of hold:
  - if mode=1, scanning resumes with the remaining dwell count;
  - if mode=0, chan_out <= sel at the next edge.

Mode switching:
- MANUAL->SCAN (hold=0): counter starts at 0 and scanning begins from the current chan_out. The first advance occurs DWELL cycles after the switch.
- SCAN->MANUAL: counter is cleared and chan_out <= sel at the same edge.

chan_change:
- chan_change <= (chan_next != chan_out), in every state.
- It is never asserted in the cycle after reset.
- A manual sel equal to the current channel produces no pulse.

Test Plan:
1. WIDTH=4, CHANNELS=4; data_in=16'hDCBA, mode=0, sel=2 after reset -> next cycle data_out=4'hC, chan_out=2, chan_change=1 for exactly 1 cycle. Holding sel=2 -> chan_change=0.
2. mode=1, DWELL=3, starting chan_out=0 -> chan_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. data_out follows A,B,C,D,A. chan_change pulses on each transition, including 3->0.
3. SCAN with hold=1 asserted one cycle into a dwell for 5 cycles, while data_in changes to 16'h4321 -> data_out and chan_out frozen for 5 cycles. After release, the channel advances after exactly 2 further cycles.
4. CHANNELS=3, mode=0, sel=3 -> sel_err=1, data_out=0, chan_out unchanged. Then sel=1 -> sel_err=0, data_out=word 1.
5. SCAN mid-dwell on channel 2, then reset=1 for one edge -> all outputs 0 and state MANUAL. Subsequent mode=1 scans from channel 0 with a full dwell.
6. Toggle mode 1->0 with sel=3 while on channel 1 -> chan_out=3, data_out=4'hD at the next edge, one chan_change pulse.
